// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - stage index constants (IF .. WB) and the default pipeline depth
//   - fixed-width stage vector / stage index types used for the selection logic
//   - oldest_idx(): index of the highest set bit (the oldest stage) of a vector
//   - stage_onehot(): one-hot stage vector from a stage index
//   - ctrl_mode_e: the per-cycle decision taken by the controller
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int unsigned STG_IF     = 32'd0;
    localparam int unsigned STG_ID     = 32'd1;
    localparam int unsigned STG_EX     = 32'd2;
    localparam int unsigned STG_MEM    = 32'd3;
    localparam int unsigned STG_WB     = 32'd4;
    localparam int unsigned NSTAGE_DEF = 32'd5;

    // Selection works on a fixed maximum width; narrower pipelines zero-extend.
    localparam int unsigned MAX_NSTAGE = 32'd32;
    localparam int unsigned IDX_W      = 32'd5;

    typedef logic [MAX_NSTAGE-1:0] stage_vec_t;
    typedef logic [IDX_W-1:0]      stage_idx_t;

    typedef enum logic [1:0] {
        MODE_IDLE     = 2'd0,
        MODE_REDIRECT = 2'd1,
        MODE_STALL    = 2'd2
    } ctrl_mode_e;

    // Highest set bit wins: later stages hold older instructions.
    // Returns 0 for an empty vector; callers qualify with a reduction-OR.
    function automatic stage_idx_t oldest_idx(input stage_vec_t vec);
        stage_idx_t idx;
        idx = {IDX_W{1'b0}};
        for (int k = 0; k < int'(MAX_NSTAGE); k++) begin
            idx = vec[k] ? stage_idx_t'(k) : idx;
        end
        return idx;
    endfunction

    function automatic stage_vec_t stage_onehot(input stage_idx_t idx);
        return {{(MAX_NSTAGE-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear (clear has priority).
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, clears the count
//   clr_i  : synchronous clear
//   inc_i  : increment request, ignored once the count is all ones
//   cnt_o  : registered count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned W = 32'd16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next count: clear beats increment, increment stops at all ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {W{1'b0}};
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Stall / flush / redirect controller for an in-order pipeline. Stage 0 is the
// PC/IF register, stage NSTAGE-1 is WB; a higher index is an older instruction.
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   stall_req_i     : per-stage hold requests
//   redirect_i      : per-stage resolved redirects (bit 0 ignored)
//   clr_cnt_i       : synchronous clear of the performance counters
//   write_o         : per-stage register write enables (bit 0 = PC)
//   flush_o         : per-stage bubble insertion (bit 0 always 0)
//   redirect_ack_o  : one-hot stage whose redirect is applied this cycle
//   pending_o       : a redirect was blocked and is being held
//   stall_cnt_o     : saturating count of cycles with a stall applied
//   redirect_cnt_o  : saturating count of applied redirects
//   hang_o          : sticky flag, PC frozen for WDOG_LIMIT consecutive cycles
// write_o / flush_o / redirect_ack_o are combinational (zero latency) from the
// inputs and the pending register.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NSTAGE       = NSTAGE_DEF,
    parameter bit          GLOBAL_STALL = 1'b0,
    parameter int unsigned CNT_W        = 32'd16,
    parameter int unsigned WDOG_LIMIT   = 32'd1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NSTAGE-1:0] stall_req_i,
    input  logic [NSTAGE-1:0] redirect_i,
    input  logic              clr_cnt_i,
    output logic [NSTAGE-1:0] write_o,
    output logic [NSTAGE-1:0] flush_o,
    output logic [NSTAGE-1:0] redirect_ack_o,
    output logic              pending_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  redirect_cnt_o,
    output logic              hang_o
);

    localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 32'd1);

    stage_vec_t        stall_vec_s;
    stage_vec_t        redir_vec_s;
    stage_vec_t        cand_vec_s;
    stage_idx_t        stall_idx_s;
    stage_idx_t        redir_idx_s;
    logic              stall_any_s;
    logic              redir_any_s;
    logic              blocked_s;
    logic              apply_s;
    logic              stall_applied_s;
    ctrl_mode_e        mode_s;

    logic [NSTAGE-1:0] write_s;
    logic [NSTAGE-1:0] flush_s;
    logic [NSTAGE-1:0] ack_s;

    logic              pend_vld_d;
    logic              pend_vld_q;
    stage_idx_t        pend_idx_d;
    stage_idx_t        pend_idx_q;

    logic [WDOG_W-1:0] wdog_cnt_s;
    logic              hang_d;
    logic              hang_q;

    // Candidate selection: oldest stall, and oldest of live redirects plus the
    // held one. A live redirect younger than the held one simply loses here,
    // which drops it without an ack since the held flush covers it.
    always_comb begin
        stall_vec_s = stage_vec_t'(stall_req_i);
        redir_vec_s = stage_vec_t'(redirect_i) & {{(MAX_NSTAGE-1){1'b1}}, 1'b0};
        if (pend_vld_q) begin
            cand_vec_s = redir_vec_s | stage_onehot(pend_idx_q);
        end else begin
            cand_vec_s = redir_vec_s;
        end
        stall_any_s = |stall_vec_s;
        redir_any_s = |cand_vec_s;
        stall_idx_s = oldest_idx(stall_vec_s);
        redir_idx_s = oldest_idx(cand_vec_s);
    end

    // Decision: a redirect must wait if an equal-or-older stage is stalled (or
    // any stage under global stall); otherwise it flushes the younger, stalled
    // stages and so overrides the stall.
    always_comb begin
        blocked_s = redir_any_s && stall_any_s &&
                    (GLOBAL_STALL || (stall_idx_s >= redir_idx_s));
        apply_s   = redir_any_s && !blocked_s;
        if (apply_s) begin
            mode_s = MODE_REDIRECT;
        end else if (stall_any_s) begin
            mode_s = MODE_STALL;
        end else begin
            mode_s = MODE_IDLE;
        end
        stall_applied_s = (mode_s == MODE_STALL);
    end

    // Per-stage enables for the chosen mode.
    always_comb begin
        write_s = {NSTAGE{1'b1}};
        flush_s = {NSTAGE{1'b0}};
        ack_s   = {NSTAGE{1'b0}};
        case (mode_s)
            MODE_REDIRECT: begin
                for (int k = 0; k < int'(NSTAGE); k++) begin
                    flush_s[k] = (k != 0) && (stage_idx_t'(k) <= redir_idx_s);
                    ack_s[k]   = (stage_idx_t'(k) == redir_idx_s);
                end
            end
            MODE_STALL: begin
                if (GLOBAL_STALL) begin
                    write_s = {NSTAGE{1'b0}};
                end else begin
                    // Freeze S and everything younger; bubble into S+1 so the
                    // stalled instruction is not duplicated downstream.
                    for (int k = 0; k < int'(NSTAGE); k++) begin
                        write_s[k] = (stage_idx_t'(k) > stall_idx_s);
                        flush_s[k] = (k != 0) && (stage_idx_t'(k - 1) == stall_idx_s);
                    end
                end
            end
            MODE_IDLE: begin
                write_s = {NSTAGE{1'b1}};
            end
            default: begin
                write_s = {NSTAGE{1'b1}};
            end
        endcase
    end

    // Outputs are held inactive while reset is asserted.
    always_comb begin
        if (!rst_n) begin
            write_o        = {NSTAGE{1'b0}};
            flush_o        = {NSTAGE{1'b0}};
            redirect_ack_o = {NSTAGE{1'b0}};
        end else begin
            write_o        = write_s;
            flush_o        = flush_s;
            redirect_ack_o = ack_s;
        end
    end

    // Pending capture: a blocked redirect is held; anything else clears it.
    always_comb begin
        pend_vld_d = blocked_s;
        if (blocked_s) begin
            pend_idx_d = redir_idx_s;
        end else begin
            pend_idx_d = {IDX_W{1'b0}};
        end
    end

    // Pending register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q <= 1'b0;
            pend_idx_q <= {IDX_W{1'b0}};
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_idx_q <= pend_idx_d;
        end
    end

    assign pending_o = pend_vld_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr_cnt_i),
        .inc_i (stall_applied_s),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr_cnt_i),
        .inc_i (apply_s),
        .cnt_o (redirect_cnt_o)
    );

    // Watchdog counts consecutive cycles with the PC frozen.
    sat_counter #(.W(WDOG_W)) u_wdog_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (write_s[0]),
        .inc_i (~write_s[0]),
        .cnt_o (wdog_cnt_s)
    );

    // Hang sets on the edge that brings the watchdog count to WDOG_LIMIT.
    always_comb begin
        if (!write_s[0] && (wdog_cnt_s == WDOG_W'(WDOG_LIMIT - 32'd1))) begin
            hang_d = 1'b1;
        end else begin
            hang_d = hang_q;
        end
    end

    // Sticky hang flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hang_q <= 1'b0;
        end else begin
            hang_q <= hang_d;
        end
    end

    assign hang_o = hang_q;

endmodule
